smi_mem_lib_write_burst_segmented_n: RTL and testbench
======================================================

SMI_MEM_LIB_WRITE_BURST_SEGMENTED_N -- requirements
Module: smi_mem_lib_write_burst_segmented_n

Interface
REQ-001 SHALL have parameter DATA_W, default 64: write data word width; 64, 128 or 256.
REQ-002 SHALL have parameter SEG_WORDS, default 32: segment size in data words; power of two; SEG_WORDS*DATA_W/8 divides 4096.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4: maximum number of issued segments awaiting completion; range 1..15.
REQ-004 SHALL use clock clk and reset srst; srst is synchronous, active-high; clk is a 1-bit input.
REQ-005 srst  in  1  synchronous active-high reset.
REQ-006 params_valid/params_stop  in/out  1/1  transfer parameter handshake.
REQ-007 param_addr  in  64  start byte address; bits below log2(DATA_W/8) are ignored.
REQ-008 param_len  in  32  transfer length in data words.
REQ-009 param_opts  in  8  burst options, passed to every segment.
REQ-010 write_valid/write_data/write_stop  in/in/out  1/DATA_W/1  write data stream.
REQ-011 seg_valid/seg_addr/seg_len/seg_opts/seg_stop  out/out/out/out/in  1/64/13/8/1  segment command to the burst core; seg_len is in bytes.
REQ-012 flit_valid/flit_data/flit_eofc/flit_stop  out/out/out/in  1/64/8/1  64-bit flit stream to the burst core.
REQ-013 seg_done_valid/seg_done_ok/seg_done_stop  in/in/out  1/1/1  per-segment completion status.
REQ-014 done_valid/done_status_ok/done_stop  out/out/in  1/1/1  transfer completion.

Function
REQ-015 All handshakes SHALL use the SELF convention: a transfer occurs on a clk edge with valid=1 and stop=0.
REQ-016 States SHALL be IDLE, SETUP, ISSUE, COPY, NEXT, FLUSH and DONE.
REQ-017 IDLE: params_stop=0; on a parameter transfer, SHALL capture the parameters and go to SETUP; params_stop SHALL be 1 in every other state.
REQ-018 SETUP: first segment length = min(param_len, SEG_WORDS - (word_addr mod SEG_WORDS)); if param_len=0, SHALL go to FLUSH with no segment issued.
REQ-019 ISSUE: seg_valid SHALL assert only while outstanding < MAX_OUTSTANDING; on transfer, SHALL go to COPY.
REQ-020 seg_len SHALL equal words*DATA_W/8; no segment SHALL cross a (SEG_WORDS*DATA_W/8)-byte aligned boundary.
REQ-021 COPY: each write word SHALL be emitted as DATA_W/64 flits, low 64 bits first; write_stop=0 only when the last flit of the word transfers.
REQ-022 flit_eofc SHALL be 8 on the final flit of a segment and 0 otherwise.
REQ-023 NEXT: SHALL advance the address by the segment bytes, then take min(remaining, SEG_WORDS) words; SHALL go to ISSUE if remaining > 0, else to FLUSH.
REQ-024 outstanding SHALL increment on a seg transfer and decrement on a seg_done transfer; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-025 seg_done_stop SHALL be 0 whenever outstanding > 0.
REQ-026 Aggregate status SHALL be set to 1 in SETUP and ANDed with seg_done_ok on each seg_done transfer.
REQ-027 FLUSH: SHALL go to DONE when outstanding = 0.
REQ-028 DONE: done_valid=1 with done_status_ok = aggregate status; on transfer, SHALL go to IDLE.
REQ-029 The first seg_valid SHALL assert 2 cycles after the parameter transfer, given outstanding < MAX_OUTSTANDING.

Reset
REQ-030 On srst the block SHALL enter IDLE with outstanding=0 and serialiser empty; datapath registers are not reset.
REQ-031 During reset, all valid outputs SHALL be 0 and params_stop=0, write_stop=1, seg_done_stop=1; srst mid-transfer SHALL abandon the transfer with no done.

Configuration
REQ-032 With SMI_WRITE_SEG_ERR_COUNT_EN defined, the block SHALL add output done_err_count[15:0], equal to the number of seg_done_ok=0 transfers in the current transfer and saturating at 0xFFFF.
REQ-033 Without SMI_WRITE_SEG_ERR_COUNT_EN, the port and counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-034 A shared package SHALL hold the state enum, the EOFC_LAST=8 constant and a segment-length function.
REQ-035 The DATA_W-to-64 flit serialiser SHALL be a sub-module, smi_mem_lib_flit_serialiser.

Verification
REQ-036 DATA_W=64, SEG_WORDS=32, addr 0x0FF0, len 4 -> segments (0x0FF0, 16 B) and (0x1000, 16 B); done_status_ok=1.
REQ-037 DATA_W=128, SEG_WORDS=16, addr 0, len 3 -> one segment of 48 B, 6 flits, eofc=8 only on flit 6, low half of each word first.
REQ-038 len 0 -> no seg_valid; done_valid with done_status_ok=1.
REQ-039 MAX_OUTSTANDING=2, addr 0, len 96, seg_done_valid held 0 -> third seg_valid withheld until the first seg_done transfer.
REQ-040 Second of three segments returns ok=0 -> done_status_ok=0; with the macro defined, done_err_count=1.
REQ-041 srst asserted mid-COPY -> next cycle IDLE, params_stop=0, no done_valid; a following transfer completes normally.

Source files
------------

// File: rtl/smi_mem_lib_write_burst_segmented_n_pkg.sv
// rtl/smi_mem_lib_write_burst_segmented_n_pkg.sv - shared types, constants and helpers for the segmented write burst block
package smi_mem_lib_write_burst_segmented_n_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    COPY,
    NEXT,
    FLUSH,
    DONE
  } state_t;

  // End-of-frame code carried on the final flit of each segment.
  localparam logic [7:0] EOFC_LAST = 8'd8;

  // Words that fit before the next segment boundary, capped by what is left to send.
  function automatic logic [31:0] seg_words_calc(input logic [31:0] len,
                                                 input logic [31:0] word_offset,
                                                 input logic [31:0] seg_words);
    logic [31:0] room;
    room = seg_words - word_offset;
    return (len < room) ? len : room;
  endfunction

endpackage

// File: rtl/smi_mem_lib_flit_serialiser.sv
// rtl/smi_mem_lib_flit_serialiser.sv - splits DATA_W write words into 64-bit flits, low half first
module smi_mem_lib_flit_serialiser #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              enable,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  output logic              word_stop,
  output logic              flit_valid,
  output logic [63:0]       flit_data,
  output logic              flit_last,
  input  logic              flit_stop
);

  localparam int FLITS = DATA_W / 64;
  localparam int IDX_W = (FLITS > 1) ? $clog2(FLITS) : 1;

  logic [IDX_W-1:0] idx;
  logic             fire;

  // The word is held upstream until its last flit leaves, so no local word buffer is needed.
  assign flit_valid = enable && word_valid;
  assign flit_data  = word_data[64*int'(idx) +: 64];
  assign flit_last  = (idx == IDX_W'(FLITS - 1));
  assign fire       = flit_valid && !flit_stop;
  assign word_stop  = !(fire && flit_last);

  // Flit index within the current word; wraps after the last flit.
  always_ff @(posedge clk) begin
    if (srst) begin
      idx <= '0;
    end else if (fire) begin
      idx <= flit_last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/smi_mem_lib_write_burst_segmented_n.sv
// rtl/smi_mem_lib_write_burst_segmented_n.sv - splits a write transfer into boundary-aligned segments; optional SMI_WRITE_SEG_ERR_COUNT_EN adds done_err_count
module smi_mem_lib_write_burst_segmented_n
  import smi_mem_lib_write_burst_segmented_n_pkg::*;
#(
  parameter int DATA_W          = 64,
  parameter int SEG_WORDS       = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              params_valid,
  output logic              params_stop,
  input  logic [63:0]       param_addr,
  input  logic [31:0]       param_len,
  input  logic [7:0]        param_opts,
  input  logic              write_valid,
  input  logic [DATA_W-1:0] write_data,
  output logic              write_stop,
  output logic              seg_valid,
  output logic [63:0]       seg_addr,
  output logic [12:0]       seg_len,
  output logic [7:0]        seg_opts,
  input  logic              seg_stop,
  output logic              flit_valid,
  output logic [63:0]       flit_data,
  output logic [7:0]        flit_eofc,
  input  logic              flit_stop,
  input  logic              seg_done_valid,
  input  logic              seg_done_ok,
  output logic              seg_done_stop,
  output logic              done_valid,
  output logic              done_status_ok,
  input  logic              done_stop
`ifdef SMI_WRITE_SEG_ERR_COUNT_EN
  ,
  output logic [15:0]       done_err_count
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(BYTES);

  state_t      state;
  logic [63:0] addr;
  logic [31:0] remaining;
  logic [31:0] cur_words;
  logic [31:0] seg_left;
  logic [7:0]  opts;
  logic        agg_ok;
  logic [3:0]  outstanding;
  logic [31:0] word_off;
  logic        seg_fire;
  logic        done_fire;
  logic        word_fire;
  logic        word_last;
  logic        ser_enable;

  assign word_off  = 32'((addr >> ADDR_LSB) & 64'(SEG_WORDS - 1));

  assign params_stop    = !srst && (state != IDLE);
  assign seg_valid      = !srst && (state == ISSUE) && (outstanding < 4'(MAX_OUTSTANDING));
  assign seg_addr       = addr;
  assign seg_len        = 13'(cur_words * 32'(BYTES));
  assign seg_opts       = opts;
  assign seg_done_stop  = srst || (outstanding == 4'd0);
  assign done_valid     = !srst && (state == DONE);
  assign done_status_ok = agg_ok;
  assign ser_enable     = !srst && (state == COPY);

  assign seg_fire  = seg_valid && !seg_stop;
  assign done_fire = seg_done_valid && !seg_done_stop;
  assign word_fire = flit_valid && !flit_stop && word_last;
  assign flit_eofc = (flit_valid && word_last && (seg_left == 32'd1)) ? EOFC_LAST : 8'd0;

  smi_mem_lib_flit_serialiser #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk       (clk),
    .srst      (srst),
    .enable    (ser_enable),
    .word_valid(write_valid),
    .word_data (write_data),
    .word_stop (write_stop),
    .flit_valid(flit_valid),
    .flit_data (flit_data),
    .flit_last (word_last),
    .flit_stop (flit_stop)
  );

  // Transfer sequencing: capture, carve segments at boundaries, copy words, wait for completions.
  always_ff @(posedge clk) begin
    if (srst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (params_valid) begin
            addr      <= param_addr & ~64'(BYTES - 1);
            remaining <= param_len;
            opts      <= param_opts;
            state     <= SETUP;
          end
        end
        SETUP: begin
          cur_words <= seg_words_calc(remaining, word_off, 32'(SEG_WORDS));
          state     <= (remaining == 32'd0) ? FLUSH : ISSUE;
        end
        ISSUE: begin
          if (seg_fire) begin
            seg_left  <= cur_words;
            remaining <= remaining - cur_words;
            state     <= COPY;
          end
        end
        COPY: begin
          if (word_fire) begin
            seg_left <= seg_left - 32'd1;
            if (seg_left == 32'd1) state <= NEXT;
          end
        end
        NEXT: begin
          // After the first segment the address is aligned, so only the cap applies.
          addr      <= addr + 64'(cur_words * 32'(BYTES));
          cur_words <= seg_words_calc(remaining, 32'd0, 32'(SEG_WORDS));
          state     <= (remaining != 32'd0) ? ISSUE : FLUSH;
        end
        FLUSH: begin
          if (outstanding == 4'd0) state <= DONE;
        end
        DONE: begin
          if (!done_stop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issued-but-uncompleted segment count; simultaneous issue and completion cancel.
  always_ff @(posedge clk) begin
    if (srst) begin
      outstanding <= 4'd0;
    end else begin
      case ({seg_fire, done_fire})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Aggregate completion status for the current transfer.
  always_ff @(posedge clk) begin
    if (state == SETUP) begin
      agg_ok <= 1'b1;
    end else if (done_fire) begin
      agg_ok <= agg_ok & seg_done_ok;
    end
  end

`ifdef SMI_WRITE_SEG_ERR_COUNT_EN
  logic [15:0] err_cnt;

  assign done_err_count = err_cnt;

  // Saturating count of failed segment completions in the current transfer.
  always_ff @(posedge clk) begin
    if (state == SETUP) begin
      err_cnt <= 16'd0;
    end else if (done_fire && !seg_done_ok && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_smi_mem_lib_write_burst_segmented_n.sv
// tb/tb_smi_mem_lib_write_burst_segmented_n.sv - directed vectors for the segmented write burst block
module tb_smi_mem_lib_write_burst_segmented_n;

  localparam logic [63:0] PAT = 64'hA5A5_0000_0000_0000;

  logic clk = 1'b0;
  logic srst;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // DUT A: 64-bit words, 32-word segments, two outstanding
  logic        a_params_valid, a_params_stop;
  logic [63:0] a_param_addr;
  logic [31:0] a_param_len;
  logic [7:0]  a_param_opts;
  logic        a_write_valid, a_write_stop;
  logic [63:0] a_write_data;
  logic        a_seg_valid, a_seg_stop;
  logic [63:0] a_seg_addr;
  logic [12:0] a_seg_len;
  logic [7:0]  a_seg_opts;
  logic        a_flit_valid, a_flit_stop;
  logic [63:0] a_flit_data;
  logic [7:0]  a_flit_eofc;
  logic        a_seg_done_valid, a_seg_done_ok, a_seg_done_stop;
  logic        a_done_valid, a_done_status_ok, a_done_stop;
`ifdef SMI_WRITE_SEG_ERR_COUNT_EN
  logic [15:0] a_done_err_count;
  logic [15:0] b_done_err_count;
`endif

  // DUT B: 128-bit words, 16-word segments
  logic         b_params_valid, b_params_stop;
  logic [63:0]  b_param_addr;
  logic [31:0]  b_param_len;
  logic [7:0]   b_param_opts;
  logic         b_write_valid, b_write_stop;
  logic [127:0] b_write_data;
  logic         b_seg_valid, b_seg_stop;
  logic [63:0]  b_seg_addr;
  logic [12:0]  b_seg_len;
  logic [7:0]   b_seg_opts;
  logic         b_flit_valid, b_flit_stop;
  logic [63:0]  b_flit_data;
  logic [7:0]   b_flit_eofc;
  logic         b_seg_done_valid, b_seg_done_ok, b_seg_done_stop;
  logic         b_done_valid, b_done_status_ok, b_done_stop;

  smi_mem_lib_write_burst_segmented_n #(.DATA_W(64), .SEG_WORDS(32), .MAX_OUTSTANDING(2)) u_a (
    .clk(clk), .srst(srst),
    .params_valid(a_params_valid), .params_stop(a_params_stop),
    .param_addr(a_param_addr), .param_len(a_param_len), .param_opts(a_param_opts),
    .write_valid(a_write_valid), .write_data(a_write_data), .write_stop(a_write_stop),
    .seg_valid(a_seg_valid), .seg_addr(a_seg_addr), .seg_len(a_seg_len), .seg_opts(a_seg_opts),
    .seg_stop(a_seg_stop),
    .flit_valid(a_flit_valid), .flit_data(a_flit_data), .flit_eofc(a_flit_eofc), .flit_stop(a_flit_stop),
    .seg_done_valid(a_seg_done_valid), .seg_done_ok(a_seg_done_ok), .seg_done_stop(a_seg_done_stop),
    .done_valid(a_done_valid), .done_status_ok(a_done_status_ok), .done_stop(a_done_stop)
`ifdef SMI_WRITE_SEG_ERR_COUNT_EN
    , .done_err_count(a_done_err_count)
`endif
  );

  smi_mem_lib_write_burst_segmented_n #(.DATA_W(128), .SEG_WORDS(16), .MAX_OUTSTANDING(4)) u_b (
    .clk(clk), .srst(srst),
    .params_valid(b_params_valid), .params_stop(b_params_stop),
    .param_addr(b_param_addr), .param_len(b_param_len), .param_opts(b_param_opts),
    .write_valid(b_write_valid), .write_data(b_write_data), .write_stop(b_write_stop),
    .seg_valid(b_seg_valid), .seg_addr(b_seg_addr), .seg_len(b_seg_len), .seg_opts(b_seg_opts),
    .seg_stop(b_seg_stop),
    .flit_valid(b_flit_valid), .flit_data(b_flit_data), .flit_eofc(b_flit_eofc), .flit_stop(b_flit_stop),
    .seg_done_valid(b_seg_done_valid), .seg_done_ok(b_seg_done_ok), .seg_done_stop(b_seg_done_stop),
    .done_valid(b_done_valid), .done_status_ok(b_done_status_ok), .done_stop(b_done_stop)
`ifdef SMI_WRITE_SEG_ERR_COUNT_EN
    , .done_err_count(b_done_err_count)
`endif
  );

  typedef struct {
    logic [63:0]       addr;
    int                len;
    logic [7:0]        okmask;
    int                hold;
    int                nseg;
    logic [2:0][63:0]  sa;
    logic [2:0][12:0]  sl;
    logic              ok;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] addr, input int len, input logic [7:0] okmask,
                              input int hold, input int nseg,
                              input logic [63:0] a0, input int l0, input logic [63:0] a1, input int l1,
                              input logic [63:0] a2, input int l2, input logic ok);
    vec_t v;
    v.addr = addr; v.len = len; v.okmask = okmask; v.hold = hold; v.nseg = nseg;
    v.sa[0] = a0; v.sa[1] = a1; v.sa[2] = a2;
    v.sl[0] = 13'(l0); v.sl[1] = 13'(l1); v.sl[2] = 13'(l2);
    v.ok = ok;
    return v;
  endfunction

  task automatic check_reset_outputs();
    check("rst_params_stop", a_params_stop, 0);
    check("rst_write_stop", a_write_stop, 1);
    check("rst_seg_done_stop", a_seg_done_stop, 1);
    check("rst_seg_valid", a_seg_valid, 0);
    check("rst_flit_valid", a_flit_valid, 0);
    check("rst_done_valid", a_done_valid, 0);
  endtask

  // Cycle-stepped driver and scoreboard for DUT A; abort_flits>0 leaves mid-copy without checking.
  task automatic run_a(input vec_t v, input int abort_flits);
    logic [63:0] la[8];
    logic [12:0] ll[8];
    int nseg, pend, didx, nflit, wcnt, fis, fseg, ferr, eerr, pcyc, fvcyc, third_cyc, fdone, experr;
    logic got_done, st, pdone, aborted;
    logic [7:0] exp_e;
    logic [15:0] errc;
    nseg = 0; pend = 0; didx = 0; nflit = 0; wcnt = 0; fis = 0; fseg = 0; ferr = 0; eerr = 0;
    pcyc = -1; fvcyc = -1; third_cyc = -1; fdone = -1; experr = 0;
    got_done = 0; st = 0; pdone = 0; aborted = 0; errc = 0;
    for (int i = 0; i < 8; i++) begin la[i] = '0; ll[i] = '0; end
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      @(negedge clk);
      a_params_valid   = !pdone;
      a_param_addr     = v.addr;
      a_param_len      = 32'(v.len);
      a_param_opts     = 8'h5A ^ 8'(v.len);
      a_seg_stop       = (cyc % 5 == 3);
      a_flit_stop      = (cyc % 3 == 2);
      a_write_valid    = 1'b1;
      a_write_data     = PAT + 64'(wcnt);
      a_seg_done_valid = (pend > 0) && (cyc >= v.hold);
      a_seg_done_ok    = v.okmask[didx % 8];
      a_done_stop      = (cyc % 2 == 1);
      #1;
      if (pend > 0 && a_seg_done_stop) ferr++;
      if (a_params_valid && !a_params_stop) begin pdone = 1; pcyc = cyc; end
      if (a_seg_valid && fvcyc < 0) fvcyc = cyc;
      if (a_seg_valid && !a_seg_stop) begin
        if (nseg < 8) begin la[nseg] = a_seg_addr; ll[nseg] = a_seg_len; end
        if (a_seg_opts !== (8'h5A ^ 8'(v.len))) ferr++;
        if (nseg == 2) third_cyc = cyc;
        nseg++; pend++;
      end
      if (a_flit_valid && !a_flit_stop) begin
        if (a_flit_data !== PAT + 64'(nflit)) ferr++;
        exp_e = (fseg < 8 && fis == int'(ll[fseg]) / 8 - 1) ? 8'd8 : 8'd0;
        if (a_flit_eofc !== exp_e) eerr++;
        nflit++; fis++;
        if (fseg < 8 && fis == int'(ll[fseg]) / 8) begin fseg++; fis = 0; end
      end
      if (a_write_valid && !a_write_stop) wcnt++;
      if (a_seg_done_valid && !a_seg_done_stop) begin
        pend--; didx++;
        if (fdone < 0) fdone = cyc;
      end
      if (a_done_valid && !a_done_stop) begin
        got_done = 1; st = a_done_status_ok;
`ifdef SMI_WRITE_SEG_ERR_COUNT_EN
        errc = a_done_err_count;
`endif
      end
      if (abort_flits > 0 && nflit >= abort_flits) begin aborted = 1; break; end
      @(posedge clk);
    end
    if (!aborted) begin
      check("done_seen", got_done, 1);
      check("done_status_ok", st, v.ok);
      check("seg_count", 64'(nseg), 64'(v.nseg));
      for (int i = 0; i < v.nseg && i < 3; i++) begin
        check("seg_addr", la[i], v.sa[i]);
        check("seg_len", ll[i], v.sl[i]);
      end
      check("flit_count", 64'(nflit), 64'(v.len));
      check("flit_data_errs", 64'(ferr), 0);
      check("flit_eofc_errs", 64'(eerr), 0);
      if (v.len > 0) check("first_seg_latency", 64'(fvcyc - pcyc), 2);
      else check("seg_valid_seen", fvcyc >= 0, 0);
      if (v.hold > 0) check("third_seg_after_done", third_cyc > fdone, 1);
      for (int i = 0; i < v.nseg; i++) if (!v.okmask[i]) experr++;
`ifdef SMI_WRITE_SEG_ERR_COUNT_EN
      check("done_err_count", errc, 64'(experr));
`endif
    end
  endtask

  // DUT B: 3 words of 128 bits at address 0, flits checked one by one.
  task automatic run_b();
    int pend, nflit, wcnt, nseg;
    logic got_done, st, pdone;
    logic [63:0] ef;
    logic [7:0] ee;
    pend = 0; nflit = 0; wcnt = 0; nseg = 0; got_done = 0; st = 0; pdone = 0;
    for (int cyc = 0; cyc < 500 && !got_done; cyc++) begin
      @(negedge clk);
      b_params_valid   = !pdone;
      b_param_addr     = 64'h0;
      b_param_len      = 32'd3;
      b_param_opts     = 8'h11;
      b_seg_stop       = 1'b0;
      b_flit_stop      = (cyc % 2 == 1);
      b_write_valid    = 1'b1;
      b_write_data     = {64'h1111_0000_0000_0000 + 64'(wcnt), 64'h2222_0000_0000_0000 + 64'(wcnt)};
      b_seg_done_valid = (pend > 0);
      b_seg_done_ok    = 1'b1;
      b_done_stop      = 1'b0;
      #1;
      if (b_params_valid && !b_params_stop) pdone = 1;
      if (b_seg_valid && !b_seg_stop) begin
        check("b_seg_addr", b_seg_addr, 0);
        check("b_seg_len", b_seg_len, 48);
        nseg++; pend++;
      end
      if (b_flit_valid && !b_flit_stop) begin
        ef = (nflit % 2 == 0) ? 64'h2222_0000_0000_0000 + 64'(nflit / 2)
                              : 64'h1111_0000_0000_0000 + 64'(nflit / 2);
        ee = (nflit == 5) ? 8'd8 : 8'd0;
        check("b_flit_data", b_flit_data, ef);
        check("b_flit_eofc", b_flit_eofc, ee);
        nflit++;
      end
      if (b_write_valid && !b_write_stop) wcnt++;
      if (b_seg_done_valid && !b_seg_done_stop) pend--;
      if (b_done_valid && !b_done_stop) begin got_done = 1; st = b_done_status_ok; end
      @(posedge clk);
    end
    check("b_seg_count", 64'(nseg), 1);
    check("b_flit_count", 64'(nflit), 6);
    check("b_done_seen", got_done, 1);
    check("b_done_status_ok", st, 1);
  endtask

  initial begin
    vec_t rv;
    int late_done;
    vecs[0] = mk(64'h0FF0, 4, 8'hFF, 0, 2, 64'h0FF0, 16, 64'h1000, 16, 64'h0, 0, 1'b1);
    vecs[1] = mk(64'h0, 0, 8'hFF, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0, 1'b1);
    vecs[2] = mk(64'h0, 96, 8'hFF, 150, 3, 64'h0, 256, 64'h100, 256, 64'h200, 256, 1'b1);
    vecs[3] = mk(64'h10007, 5, 8'hFF, 0, 1, 64'h10000, 40, 64'h0, 0, 64'h0, 0, 1'b1);
    vecs[4] = mk(64'h0, 70, 8'hFD, 0, 3, 64'h0, 256, 64'h100, 256, 64'h200, 48, 1'b0);
    vecs[5] = mk(64'hF8, 40, 8'hFF, 0, 3, 64'hF8, 8, 64'h100, 256, 64'h200, 56, 1'b1);

    srst = 1'b1;
    a_params_valid = 0; a_param_addr = 0; a_param_len = 0; a_param_opts = 0;
    a_write_valid = 1; a_write_data = 0; a_seg_stop = 0; a_flit_stop = 0;
    a_seg_done_valid = 1; a_seg_done_ok = 1; a_done_stop = 0;
    b_params_valid = 0; b_param_addr = 0; b_param_len = 0; b_param_opts = 0;
    b_write_valid = 0; b_write_data = 0; b_seg_stop = 0; b_flit_stop = 0;
    b_seg_done_valid = 0; b_seg_done_ok = 1; b_done_stop = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs();
    srst = 1'b0;
    a_seg_done_valid = 0;

    for (int i = 0; i < 6; i++) run_a(vecs[i], 0);

    // Reset in the middle of copying, then a clean transfer.
    rv = vecs[2];
    rv.hold = 0;
    run_a(rv, 10);
    srst = 1'b1;
    a_params_valid = 0; a_write_valid = 1; a_flit_stop = 0; a_seg_done_valid = 1;
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    a_write_valid = 0; a_seg_done_valid = 0;
    #1;
    check("post_rst_params_stop", a_params_stop, 0);
    check("post_rst_seg_valid", a_seg_valid, 0);
    late_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_done_valid) late_done++;
    end
    check("post_rst_done_valid", 64'(late_done), 0);
    run_a(vecs[0], 0);

    run_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
